// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel/window types for the 3x3 window and convolution stages
package img_pkg;

   localparam int DEF_PIX_W = 8;

   // Window byte indices, k = 3*row + col, row 0 oldest, col 0 oldest
   localparam int TL = 0;
   localparam int TM = 1;
   localparam int TR = 2;
   localparam int ML = 3;
   localparam int MM = 4;
   localparam int MR = 5;
   localparam int BL = 6;
   localparam int BM = 7;
   localparam int BR = 8;

   typedef logic [8:0][DEF_PIX_W-1:0] window_t;

endpackage

// File: rtl/window_gen_3x3_if.sv
// rtl/window_gen_3x3_if.sv - pixel-in / window-out handshake bundle
interface window_gen_3x3_if
   import img_pkg::*;
#(
   parameter int PIX_W = DEF_PIX_W
);
   logic               i_valid;
   logic [PIX_W-1:0]   i_data;
   logic               o_ready;
   logic               i_ready;
   logic [9*PIX_W-1:0] o_data;
   logic               o_valid;
   logic               o_last;

   modport slave (
      input  i_valid, i_data, i_ready,
      output o_ready, o_data, o_valid, o_last
   );

   modport master (
      output i_valid, i_data, i_ready,
      input  o_ready, o_data, o_valid, o_last
   );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-clock row RAM, async read, read-before-write
module line_buffer
   import img_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int WIDTH = DEF_PIX_W
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; row gating upstream masks stale data
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_addr];
endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - raster pixel stream to 3x3 interior neighbourhood windows
module window_gen_3x3
   import img_pkg::*;
#(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int PIX_W      = DEF_PIX_W
) (
   input  logic           i_clk,
   input  logic           i_reset,
   window_gen_3x3_if.slave bus
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(2);
   localparam logic [RW-1:0] ROW_MIN  = RW'(2);

   logic [CW-1:0]        col;
   logic [RW-1:0]        row;
   logic [PIX_W-1:0]     lb1_rd;
   logic [PIX_W-1:0]     lb2_rd;
   logic [PIX_W-1:0]     taps  [9];
   logic [PIX_W-1:0]     win_n [9];
   logic [9*PIX_W-1:0]   win_flat;
   logic                 accept;
   logic                 in_window;
   logic                 o_valid_q;
   logic                 o_last_q;
   logic [9*PIX_W-1:0]   o_data_q;

   assign bus.o_ready = !o_valid_q || bus.i_ready;
   assign bus.o_valid = o_valid_q;
   assign bus.o_last  = o_last_q;
   assign bus.o_data  = o_data_q;

   assign accept    = bus.i_valid && bus.o_ready;
   assign in_window = (row >= ROW_MIN) && (col >= COL_MIN);

   // lb1 holds the previous row, lb2 the row before it; lb1 cascades into lb2
   line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
      .i_clk   (i_clk),
      .i_we    (accept),
      .i_addr  (col),
      .i_wdata (bus.i_data),
      .o_rdata (lb1_rd)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb2 (
      .i_clk   (i_clk),
      .i_we    (accept),
      .i_addr  (col),
      .i_wdata (lb1_rd),
      .o_rdata (lb2_rd)
   );

   // Post-shift tap view: each row moves left one column, new column enters on the right
   always_comb begin
      win_flat = '0;
      for (int r = 0; r < 3; r++) begin
         win_n[3*r]     = taps[3*r + 1];
         win_n[3*r + 1] = taps[3*r + 2];
      end
      win_n[TR] = lb2_rd;
      win_n[MR] = lb1_rd;
      win_n[BR] = bus.i_data;
      for (int k = 0; k < 9; k++) begin
         win_flat[PIX_W*k +: PIX_W] = win_n[k];
      end
   end

   // Raster position counters and tap shift, advanced only on accept
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         col <= '0;
         row <= '0;
         for (int k = 0; k < 9; k++) begin
            taps[k] <= '0;
         end
      end else if (accept) begin
         for (int k = 0; k < 9; k++) begin
            taps[k] <= win_n[k];
         end
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Output register: load on an interior accept, otherwise drain when downstream takes it
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_valid_q <= 1'b0;
         o_last_q  <= 1'b0;
         o_data_q  <= '0;
      end else if (accept && in_window) begin
         o_valid_q <= 1'b1;
         o_data_q  <= win_flat;
         o_last_q  <= (row == ROW_LAST) && (col == COL_LAST);
      end else if (bus.i_ready) begin
         o_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - scoreboard bench for window_gen_3x3
module tb_window_gen_3x3;
   import img_pkg::*;

   localparam int W = 8;
   localparam int H = 6;
   localparam logic [71:0] SMOKE_WIN = 72'h22_21_20_12_11_10_02_01_00;
   localparam logic [71:0] LAST_WIN  = 72'h57_56_55_47_46_45_37_36_35;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   window_gen_3x3_if #(.PIX_W(8)) bus ();

   window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [71:0] data;
      logic        last;
   } exp_t;

   exp_t        sb [$];
   exp_t        mon_e;
   int          n_chk       = 0;
   int          n_fail      = 0;
   int          pr          = 0;
   int          pc          = 0;
   int          n_acc       = 0;
   int          win_cnt     = 0;
   int          frames_done = 0;
   logic        obs_valid;
   logic [71:0] obs_data;
   logic [71:0] last_data   = '0;
   logic [71:0] held;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic logic [7:0] pix(input int r, input int c);
      return 8'(16*r + c);
   endfunction

   function automatic logic [71:0] model_win(input int r, input int c);
      window_t w;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            w[3*i + j] = pix(r - 2 + i, c - 2 + j);
         end
      end
      return w;
   endfunction

   // One clock of stimulus; pushes the expected window when this beat will be accepted
   task automatic cycle(input logic v, input logic rdy);
      exp_t e;
      @(posedge clk);
      #1;
      obs_valid   = bus.o_valid;
      obs_data    = bus.o_data;
      bus.i_valid = v;
      bus.i_ready = rdy;
      bus.i_data  = pix(pr, pc);
      #1;
      if (v && bus.o_ready) begin
         n_acc++;
         if (pr >= 2 && pc >= 2) begin
            e.data = model_win(pr, pc);
            e.last = (pr == H-1) && (pc == W-1);
            sb.push_back(e);
         end
         if (pc == W-1) begin
            pc = 0;
            pr = (pr == H-1) ? 0 : pr + 1;
         end else begin
            pc++;
         end
      end
   endtask

   // Monitor: every transferred window is popped and compared against the scoreboard
   always @(negedge clk) begin
      if (rst_n && bus.o_valid && bus.i_ready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_window: got %h, expected none", bus.o_data);
         end else begin
            mon_e = sb.pop_front();
            check("window_data", bus.o_data, mon_e.data);
            check("window_last", 72'(bus.o_last), 72'(mon_e.last));
            win_cnt++;
            if (bus.o_last) begin
               check("frame_windows", 72'(win_cnt), 72'(24));
               last_data = bus.o_data;
               frames_done++;
               win_cnt = 0;
            end
         end
      end
   end

   initial begin
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      bus.i_data  = '0;

      // Reset state
      #12;
      check("reset_o_valid", 72'(bus.o_valid), 72'(0));
      check("reset_o_last",  72'(bus.o_last),  72'(0));
      check("reset_o_data",  bus.o_data,       72'(0));
      check("reset_o_ready", 72'(bus.o_ready), 72'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Frame 1: smoke and full-frame checks
      for (int i = 1; i <= W*H; i++) begin
         cycle(1'b1, 1'b1);
         if (i == 19) check("smoke_no_early_win", 72'(obs_valid), 72'(0));
         if (i == 20) begin
            check("smoke_first_valid", 72'(obs_valid), 72'(1));
            check("smoke_first_data", obs_data, SMOKE_WIN);
         end
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      check("frame1_done", 72'(frames_done), 72'(1));
      check("frame1_last_win", last_data, LAST_WIN);

      // Frame 2: backpressure while a window is pending
      for (int i = 0; i < 21; i++) cycle(1'b1, 1'b1);
      for (int s = 0; s < 5; s++) begin
         cycle(1'b1, 1'b0);
         if (s == 0) held = bus.o_data;
         check("bp_o_ready", 72'(bus.o_ready), 72'(0));
         check("bp_o_valid", 72'(bus.o_valid), 72'(1));
         check("bp_data_stable", bus.o_data, held);
      end
      check("bp_held_win", held, model_win(2, 4));
      for (int i = 0; i < W*H - 21; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      check("frame2_done", 72'(frames_done), 72'(2));

      // Frames 3-5: random valid/ready stalls
      begin
         int target;
         target = n_acc + 3*W*H;
         for (int k = 0; k < 4000 && n_acc < target; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         if (n_acc < target) begin
            n_chk++;
            n_fail++;
            $display("FAIL random_timeout: accepted %0d, required %0d", n_acc, target);
         end
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
      check("random_frames_done", 72'(frames_done), 72'(5));
      check("random_sb_empty", 72'(sb.size()), 72'(0));

      // Reset mid-frame after 30 accepts
      for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1);
      @(posedge clk);
      #2;
      check("pre_reset_valid", 72'(bus.o_valid), 72'(1));
      #1;
      bus.i_valid = 1'b0;
      rst_n       = 1'b0;
      #1;
      check("reset_drop_valid", 72'(bus.o_valid), 72'(0));
      check("reset_drop_data", bus.o_data, 72'(0));
      sb.delete();
      win_cnt = 0;
      pr      = 0;
      pc      = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 1; i <= W*H; i++) begin
         cycle(1'b1, 1'b1);
         if (i == 19) check("post_reset_no_early_win", 72'(obs_valid), 72'(0));
         if (i == 20) begin
            check("post_reset_first_valid", 72'(obs_valid), 72'(1));
            check("post_reset_first_data", obs_data, SMOKE_WIN);
         end
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      check("post_reset_frame_done", 72'(frames_done), 72'(6));
      check("final_sb_empty", 72'(sb.size()), 72'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Upstream neighbour of the 3x3 convolution stage.
- Accepts a raster-order 8-bit pixel stream over a valid/ready handshake.
- Buffers the two previous image rows in on-chip line buffers.
- Emits one 72-bit 3x3 neighbourhood window per interior pixel, in the packing the convolution stage consumes. No border padding is applied; border pixels produce no window.

Parameters:
IMG_WIDTH, 512, pixels per row (>=3)
IMG_HEIGHT, 512, rows per frame (>=3)
PIX_W, 8, bits per pixel; o_data width is 9*PIX_W

Ports:
i_clk  in  1  single clock, rising-edge
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  input pixel valid
i_data  in  PIX_W  input pixel, raster order
o_ready  out  1  input accepted when i_valid && o_ready
i_ready  in  1  downstream ready
o_data  out  9*PIX_W  3x3 window
o_valid  out  1  window valid
o_last  out  1  qualifies the final window of a frame; meaningful only with o_valid

Behaviour:
- Reset (i_reset=0, asynchronous): o_valid=0, o_last=0, o_data=0, col=0, row=0, window taps=0. Line-buffer RAM contents are not cleared; row gating makes them don't-care. Reset mid-frame discards the partial frame; the next accepted pixel is treated as (row 0, col 0).
- Handshake:
  - o_ready = !o_valid || i_ready (combinational).
  - accept = i_valid && o_ready.
  - No state changes without accept, except that o_valid clears on i_ready when no new window is produced.
- Counters:
  - col increments on accept and wraps IMG_WIDTH-1 -> 0.
  - On col wrap, row increments and wraps IMG_HEIGHT-1 -> 0 (frame boundary).
  - Counter widths are $clog2 of each dimension.
- Line buffers: two RAMs of depth IMG_WIDTH, addressed by col, with asynchronous read and read-before-write. On accept:
  - lb2[col] <= lb1[col]
  - lb1[col] <= i_data
  - Consequently lb1 read = pixel(row-1, col) and lb2 read = pixel(row-2, col).
- Window taps: a 3x3 register array. On accept, each row shifts left by one column, and the new right column is {lb2[col], lb1[col], i_data} for top, mid, bottom.
- Output generation:
  - On accept with row>=2 and col>=2, the next edge loads o_data from the post-shift taps, sets o_valid=1, and sets o_last = (row==IMG_HEIGHT-1 && col==IMG_WIDTH-1).
  - Otherwise, if i_ready, o_valid<=0.
  - If o_valid && !i_ready, o_data, o_valid and o_last hold stable.
- Packing: byte k = o_data[PIX_W*k +: PIX_W], with k = 3*r + c.
  - r=0 is the oldest row (row-2); c=0 is the oldest column (col-2).
  - Byte 0 is the top-left pixel; byte 8 is the pixel just accepted.
- Latency: 1 cycle from the accepting edge to o_valid.
- Throughput and counts:
  - 1 window per cycle sustained while i_ready=1.
  - (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
  - Column taps are not flushed across row boundaries; gating on col>=2 excludes stale columns.
- Simultaneous events: o_valid && i_ready && accept producing a new window replaces the output in the same cycle with no bubble.

Decomposition:
- Shared package img_pkg:
  - PIX_W default
  - window byte-index constants (TL=0 ... BR=8)
  - window typedef: packed array of 9 pixels, also used by the convolution stage
- Sub-module line_buffer: parameters DEPTH and WIDTH; single-clock RAM with async read and write enable. Instantiated twice.
- Counters, taps and output register live in the top module.

Test Plan:
- Common stimulus (used by scenarios 1-3): IMG_WIDTH=8, IMG_HEIGHT=6; pixel(r,c) = 16*r + c; i_valid=1, i_ready=1.
- Smoke: common stimulus -> first o_valid one cycle after the 19th accept; o_data bytes 0..8 = 00,01,02,10,11,12,20,21,22.
- Full frame: common stimulus -> exactly 24 windows. The 24th has byte8=0x57, byte0=0x35 and o_last=1; o_last=0 on all others. No window is produced for col<2 or row<2.
- Backpressure: common stimulus, with i_ready held 0 for 5 cycles while o_valid=1 -> o_ready=0, o_data and o_valid stable, no pixel accepted. On release the same window transfers once, and the next window follows without loss.
- Random stalls: random i_valid and i_ready (50%) over 3 back-to-back frames -> window sequence is identical to a golden model, and per-frame counts are 24/24/24.
- Reset mid-frame: assert i_reset=0 asynchronously after 30 accepts -> o_valid drops immediately. After release, a fresh frame yields its first window after 19 accepts, with the same bytes as the smoke test.
